// File: rtl/data_mem_if.sv
// CPU data-memory request/response bundle; the CPU side drives requests, the responder answers.
interface data_mem_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte-strobed writes and a fixed programmable latency.
// One request in flight at a time; read responses are held until Read_data_Ready.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic       clk,
  input logic       resetn,
  data_mem_if.slave mem_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  is_wr_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [31:0]           wdata_q;
  logic [3:0]            strb_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] in_word;
  logic                  accept;
  logic                  commit_en;
  logic [ADDR_WIDTH-1:0] commit_word;
  logic [31:0]           commit_data;
  logic [3:0]            commit_strb;
  logic                  load_rdata;
  logic [ADDR_WIDTH-1:0] rdata_word;
  logic                  unused_addr;

  assign in_word     = mem_if.Address[ADDR_WIDTH+1:2];
  assign unused_addr = ^{mem_if.Address[31:ADDR_WIDTH+2], mem_if.Address[1:0]};
  assign accept      = (state_q == S_IDLE) && (mem_if.MemRead || mem_if.MemWrite);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit_en   = 1'b0;
    commit_word = word_q;
    commit_data = wdata_q;
    commit_strb = strb_q;
    load_rdata  = 1'b0;
    rdata_word  = word_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // MemWrite wins when both request lines are high
          if (LATENCY == 0 && mem_if.MemWrite) begin
            commit_en   = 1'b1;
            commit_word = in_word;
            commit_data = mem_if.Write_data;
            commit_strb = mem_if.Write_strb;
          end else if (LATENCY == 0) begin
            load_rdata = 1'b1;
            rdata_word = in_word;
            state_d    = S_RESP;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (is_wr_q) begin
            commit_en = 1'b1;
            state_d   = S_IDLE;
          end else begin
            load_rdata = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (mem_if.Read_data_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        is_wr_q <= mem_if.MemWrite;
        word_q  <= in_word;
        wdata_q <= mem_if.Write_data;
        strb_q  <= mem_if.Write_strb;
      end
      if (load_rdata) rdata_q <= mem_q[rdata_word];
    end
  end

  // Storage is not reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (resetn && commit_en) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_strb[i]) mem_q[commit_word][8*i +: 8] <= commit_data[8*i +: 8];
      end
    end
  end

  assign mem_if.Mem_Req_Ready   = (state_q == S_IDLE);
  assign mem_if.Read_data_Valid = (state_q == S_RESP);
  assign mem_if.Read_data       = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one LATENCY=2 responder and one LATENCY=0 responder sharing stimulus, selected by sel.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  strb = 4'd0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        rrdy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_if a_if ();
  data_mem_if z_if ();

  assign a_if.Address = addr;
  assign a_if.Write_data = wdata;
  assign a_if.Write_strb = strb;
  assign a_if.MemWrite = wr && !sel;
  assign a_if.MemRead = rd && !sel;
  assign a_if.Read_data_Ready = rrdy && !sel;
  assign z_if.Address = addr;
  assign z_if.Write_data = wdata;
  assign z_if.Write_strb = strb;
  assign z_if.MemWrite = wr && sel;
  assign z_if.MemRead = rd && sel;
  assign z_if.Read_data_Ready = rrdy && sel;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_lat2 (
    .clk(clk), .resetn(resetn), .mem_if(a_if.slave));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_lat0 (
    .clk(clk), .resetn(resetn), .mem_if(z_if.slave));

  wire        req_rdy = sel ? z_if.Mem_Req_Ready : a_if.Mem_Req_Ready;
  wire        rvld = sel ? z_if.Read_data_Valid : a_if.Read_data_Valid;
  wire [31:0] rdat = sel ? z_if.Read_data : a_if.Read_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue a write at the next edge; returns how many sampled cycles Mem_Req_Ready stayed low.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int low_cycles);
    @(negedge clk);
    addr = a; wdata = d; strb = s; wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    low_cycles = 0;
    while (!req_rdy && low_cycles < 40) begin
      low_cycles++;
      @(negedge clk);
    end
  endtask

  // Issue a read, hold Read_data_Ready low for hold cycles after Valid, then handshake.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input int exp_lat, input int hold);
    int lat;
    logic [31:0] first;
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0;
    lat = 1;
    while (!rvld && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rdat, exp);
    first = rdat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, {31'd0, rvld}, 32'd1);
      chk({tag, "_hold_data"}, rdat, first);
    end
    rrdy = 1'b1;
    @(negedge clk);
    rrdy = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, rvld}, 32'd0);
    chk({tag, "_req_rdy"}, {31'd0, req_rdy}, 32'd1);
  endtask

  initial begin
    int lc;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", {31'd0, a_if.Mem_Req_Ready}, 32'd1);
    chk("rst_vld", {31'd0, a_if.Read_data_Valid}, 32'd0);
    chk("rst_data", a_if.Read_data, 32'd0);
    resetn = 1'b1;

    do_write(32'h10, 32'hDEADBEEF, 4'b1111, lc);
    chk("wr_busy_cycles", 32'(lc), 32'd2);
    do_read("rd_full", 32'h10, 32'hDEADBEEF, 3, 0);

    do_write(32'h20, 32'h11223344, 4'b1111, lc);
    do_write(32'h20, 32'h0000AA00, 4'b0010, lc);
    do_read("rd_strb", 32'h21, 32'h1122AA44, 3, 0);
    do_write(32'h20, 32'hFFFFFFFF, 4'b0000, lc);
    chk("wr_nostrb_busy", 32'(lc), 32'd2);
    do_read("rd_nostrb", 32'h20, 32'h1122AA44, 3, 0);

    do_read("rd_bp", 32'h10, 32'hDEADBEEF, 3, 5);

    sel = 1'b1;
    do_write(32'h4, 32'hCAFEF00D, 4'b1111, lc);
    chk("l0_wr_busy", 32'(lc), 32'd0);
    do_read("l0_rd", 32'h4, 32'hCAFEF00D, 1, 0);
    sel = 1'b0;

    do_write(32'h8, 32'h00000000, 4'b1111, lc);
    @(negedge clk);
    addr = 32'h8; wdata = 32'h55555555; strb = 4'b1111; wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midrst_req_rdy", {31'd0, req_rdy}, 32'd1);
    chk("midrst_vld", {31'd0, rvld}, 32'd0);
    chk("midrst_data", rdat, 32'd0);
    do_read("rd_midrst", 32'h8, 32'h00000000, 3, 0);

    do_write(32'h1000, 32'h12345678, 4'b1111, lc);
    do_read("rd_alias", 32'h0, 32'h12345678, 3, 0);

    @(negedge clk);
    addr = 32'h30; wdata = 32'hA5A5A5A5; strb = 4'b1111; wr = 1'b1; rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rvld) seen = 1'b1;
      @(negedge clk);
    end
    chk("both_no_vld", {31'd0, seen}, 32'd0);
    chk("both_req_rdy", {31'd0, req_rdy}, 32'd1);
    do_read("rd_both", 32'h30, 32'hA5A5A5A5, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
